// File: rtl/pmp_csr.sv
// pmp_csr: CSR-side writer and holder of the RV32 PMP configuration.
// Accepts single CSR read/write requests over a valid/ready handshake and
// applies the pmpcfg WARL rules and the lock rules. It drives flattened
// pmpaddr/pmpcfg vectors to the address-match logic.
// Optional feature macro: PMP_CSR_LOCK_EN. When it is defined, locked entries
// ignore writes. When it is undefined, the L bit is stored and read back but
// never blocks a write.
module pmp_csr #(
  parameter int          NUM_ENTRIES = 16,
  parameter logic [11:0] CFG_BASE    = 12'h3A0,
  parameter logic [11:0] ADDR_BASE   = 12'h3B0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [11:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [NUM_ENTRIES*32-1:0]  pmp_addr_o,
  output logic [NUM_ENTRIES*8-1:0]   pmp_cfg_o
);

  localparam int NUM_CFG_REGS = NUM_ENTRIES / 4;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [7:0]  cfg_q  [NUM_ENTRIES];
  logic [7:0]  cfg_d  [NUM_ENTRIES];
  logic [31:0] addr_q [NUM_ENTRIES];
  logic [31:0] addr_d [NUM_ENTRIES];

  logic [31:0] rspData_q, rspData_d;
  logic        rspErr_q, rspErr_d;

  logic [11:0] cfgOff, addrOff;
  logic        isCfg, isAddr, accept;
  logic [7:0]  cfgPost;
  logic [31:0] addrPost;

  logic [NUM_ENTRIES-1:0] cfgLocked;
  logic [NUM_ENTRIES-1:0] addrLocked;

  assign accept  = req_valid && req_ready;
  // Offsets wrap to large values below the base, so one compare covers both ends.
  assign cfgOff  = req_addr - CFG_BASE;
  assign addrOff = req_addr - ADDR_BASE;
  assign isCfg   = cfgOff < 12'(NUM_CFG_REGS);
  assign isAddr  = addrOff < 12'(NUM_ENTRIES);

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rspData_q;
  assign rsp_err   = rspErr_q;

  // A written byte with R=0/W=1 is reserved, so the old byte is kept.
  // Otherwise bits 6:5 are forced to zero.
  function automatic logic [7:0] warlByte(input logic [7:0] oldVal, input logic [7:0] newVal);
    logic [7:0] result;
    if (!newVal[0] && newVal[1]) begin
      result = oldVal;
    end else begin
      result = {newVal[7], 2'b00, newVal[4:0]};
    end
    return result;
  endfunction

  // Per-entry lock decode and output flattening. An entry's pmpaddr is also
  // locked when the next entry is a locked TOR region, because that region
  // uses this pmpaddr as its lower bound.
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
`ifdef PMP_CSR_LOCK_EN
    assign cfgLocked[g] = cfg_q[g][7];
    if (g < NUM_ENTRIES - 1) begin : g_tor
      assign addrLocked[g] = cfg_q[g][7] || (cfg_q[g+1][7] && (cfg_q[g+1][4:3] == 2'b01));
    end else begin : g_last
      assign addrLocked[g] = cfg_q[g][7];
    end
`else
    assign cfgLocked[g]  = 1'b0;
    assign addrLocked[g] = 1'b0;
`endif
    assign pmp_addr_o[32*g +: 32] = addr_q[g];
    assign pmp_cfg_o[8*g +: 8]    = cfg_q[g];
  end

  // Next-state FSM: an accepted request always produces one RESP cycle.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (req_valid) begin
        state_d = RESP;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // Decode and register update. The post-write value is computed for every entry.
  // It is committed only on an accepted request to the selected CSR. It is also
  // the response data, so a read returns the stored value, and a write returns
  // the merged result after the WARL and lock rules.
  always_comb begin
    cfg_d     = cfg_q;
    addr_d    = addr_q;
    rspData_d = '0;
    rspErr_d  = !(isCfg || isAddr);
    cfgPost   = '0;
    addrPost  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfgPost = cfg_q[i];
      if (req_we && !cfgLocked[i]) begin
        cfgPost = warlByte(cfg_q[i], req_wdata[8*(i%4) +: 8]);
      end
      if (isCfg && (cfgOff == 12'(i/4))) begin
        rspData_d[8*(i%4) +: 8] = cfgPost;
        if (accept) begin
          cfg_d[i] = cfgPost;
        end
      end

      addrPost = addr_q[i];
      if (req_we && !addrLocked[i]) begin
        addrPost = req_wdata;
      end
      if (isAddr && (addrOff == 12'(i))) begin
        rspData_d = addrPost;
        if (accept) begin
          addr_d[i] = addrPost;
        end
      end
    end
  end

  // State register. Reset aborts any request that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PMP registers and the response registers, loaded on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      rspData_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
      if (accept) begin
        rspData_q <= rspData_d;
        rspErr_q  <= rspErr_d;
      end
    end
  end

endmodule

// File: tb/tb_pmp_csr.sv
// tb_pmp_csr: directed scoreboard bench for pmp_csr (16 entries).
// Expected values for the lock scenario depend on PMP_CSR_LOCK_EN.
module tb_pmp_csr;

  localparam int N = 16;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [11:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [N*32-1:0]   pmp_addr_o;
  logic [N*8-1:0]    pmp_cfg_o;

`ifdef PMP_CSR_LOCK_EN
  localparam logic [31:0] EXP_A0   = 32'h2000_0000;
  localparam logic [31:0] EXP_A1   = 32'h0000_0000;
  localparam logic [31:0] EXP_CFG0 = 32'h0000_8903;
  localparam logic [31:0] EXP_A15  = 32'hA5A5_5A5A;
`else
  localparam logic [31:0] EXP_A0   = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_A1   = 32'h1234_5678;
  localparam logic [31:0] EXP_CFG0 = 32'h0000_0003;
  localparam logic [31:0] EXP_A15  = 32'h1111_1111;
`endif

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   cycleCnt = 0;

  pmp_csr #(
    .NUM_ENTRIES (N),
    .CFG_BASE    (12'h3A0),
    .ADDR_BASE   (12'h3B0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .pmp_addr_o (pmp_addr_o),
    .pmp_cfg_o  (pmp_cfg_o)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter that the monitor uses to check response latency.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Monitor: every response cycle must match the oldest queued expectation
  // and must arrive exactly one cycle after its accept edge.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 rdata=%h, required no response", rsp_rdata);
      end else begin
        cur = expQ.pop_front();
        if (rsp_rdata !== cur.rdata || rsp_err !== cur.err) begin
          errors++;
          $display("[TB] FAIL %s: got rdata=%h err=%b, required rdata=%h err=%b",
                   cur.name, rsp_rdata, rsp_err, cur.rdata, cur.err);
        end
        checks++;
        if (cycleCnt != cur.due) begin
          errors++;
          $display("[TB] FAIL %s_latency: got cycle %0d, required cycle %0d", cur.name, cycleCnt, cur.due);
        end
      end
    end
  end

  // Watchdog so that the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Issue one request, queue its expected response, and return #1 after the accept edge.
  task automatic applyStimulus(input string name, input logic we, input logic [11:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData, input logic expErr);
    exp_t e;
    int   waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_ready: got req_ready=%b, required 1 within 10 cycles", name, req_ready);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    e.name  = name;
    e.rdata = expData;
    e.err   = expErr;
    e.due   = cycleCnt + 1;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 12'h3B0;
    req_wdata = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    checkOutput("reset_addr", 512'(pmp_addr_o), 512'd0);
    checkOutput("reset_cfg", 512'(pmp_cfg_o), 512'd0);
    checkOutput("reset_ready", 512'(req_ready), 512'd1);
    checkOutput("reset_rsp_valid", 512'(rsp_valid), 512'd0);

    applyStimulus("wr_addr0", 1'b1, 12'h3B0, 32'h2000_0000, 32'h2000_0000, 1'b0);
    checkOutput("addr0_on_accept", 512'(pmp_addr_o[31:0]), 512'(32'h2000_0000));
    applyStimulus("rd_addr0", 1'b0, 12'h3B0, 32'h0, 32'h2000_0000, 1'b0);

    applyStimulus("wr_cfg0_warl", 1'b1, 12'h3A0, 32'h0000_0F62, 32'h0000_0F00, 1'b0);
    checkOutput("cfg0_warl", 512'(pmp_cfg_o[31:0]), 512'(32'h0000_0F00));
    applyStimulus("rd_cfg0", 1'b0, 12'h3A0, 32'h0, 32'h0000_0F00, 1'b0);

    applyStimulus("wr_cfg0_lock", 1'b1, 12'h3A0, 32'h0000_8900, 32'h0000_8900, 1'b0);
    applyStimulus("wr_addr0_tor", 1'b1, 12'h3B0, 32'hFFFF_FFFF, EXP_A0, 1'b0);
    applyStimulus("wr_addr1_own", 1'b1, 12'h3B1, 32'h1234_5678, EXP_A1, 1'b0);
    applyStimulus("wr_cfg0_partial", 1'b1, 12'h3A0, 32'h0000_0003, EXP_CFG0, 1'b0);

    applyStimulus("rd_3A7_err", 1'b0, 12'h3A7, 32'h0, 32'h0, 1'b1);
    applyStimulus("rd_3C0_err", 1'b0, 12'h3C0, 32'h0, 32'h0, 1'b1);
    applyStimulus("wr_3A4_err", 1'b1, 12'h3A4, 32'hFFFF_FFFF, 32'h0, 1'b1);
    applyStimulus("wr_3C0_err", 1'b1, 12'h3C0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    checkOutput("err_no_change_cfg", 512'(pmp_cfg_o), 512'(EXP_CFG0));
    checkOutput("err_no_change_addr", 512'(pmp_addr_o), {448'd0, EXP_A1, EXP_A0});

    applyStimulus("wr_addr15", 1'b1, 12'h3BF, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0);
    checkOutput("addr15_on_accept", 512'(pmp_addr_o[511:480]), 512'(32'hA5A5_5A5A));
    applyStimulus("wr_cfg3_warl", 1'b1, 12'h3A3, 32'hE760_419F, 32'h8700_019F, 1'b0);
    checkOutput("cfg3_on_accept", 512'(pmp_cfg_o[127:96]), 512'(32'h8700_019F));
    applyStimulus("wr_addr15_lock", 1'b1, 12'h3BF, 32'h1111_1111, EXP_A15, 1'b0);
    applyStimulus("wr_addr11_napot", 1'b1, 12'h3BB, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0);
    applyStimulus("rd_addr15", 1'b0, 12'h3BF, 32'h0, EXP_A15, 1'b0);

    applyStimulus("wr_addr2_pre_rst", 1'b1, 12'h3B2, 32'hCAFE_0000, 32'hCAFE_0000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_resp_valid", 512'(rsp_valid), 512'd0);
    checkOutput("rst_resp_ready", 512'(req_ready), 512'd1);
    checkOutput("rst_resp_addr", 512'(pmp_addr_o), 512'd0);
    checkOutput("rst_resp_cfg", 512'(pmp_cfg_o), 512'd0);

    applyStimulus("rd_addr0_post_rst", 1'b0, 12'h3B0, 32'h0, 32'h0, 1'b0);
    applyStimulus("wr_addr1_post_rst", 1'b1, 12'h3B1, 32'h0000_0077, 32'h0000_0077, 1'b0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 512'(expQ.size()), 512'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
